pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Combines load-use hazards, instruction-fetch wait, data-memory busy and EX-stage redirects (taken branch or jump) into per-stage enable and flush strobes.
- Drives the PC register enable and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Keeps saturating stall and flush performance counters.

Parameters:
- REG_W, 5: register-index width.
- CNT_W, 32: performance-counter width.
- BR_PENALTY, 1: extra IF/ID bubble cycles after a redirect, legal range 0..7.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- id_rs1, input, REG_W: rs1 of the instruction in ID.
- id_rs2, input, REG_W: rs2 of the instruction in ID.
- id_uses_rs2, input, 1: the ID instruction reads rs2.
- ex_mem_read, input, 1: the EX instruction is a load.
- ex_rd, input, REG_W: destination register of the EX instruction.
- redirect, input, 1: taken branch OR jump resolved in EX; same signal as the PC stage flush.
- imem_ready, input, 1: instruction memory returns valid data this cycle.
- dmem_busy, input, 1: data memory not done; whole pipeline must freeze.
- clr_counters, input, 1: synchronous counter clear.
- pc_en, output, 1: PC register load enable.
- ifid_en, output, 1: IF/ID load enable.
- ifid_flush, output, 1: IF/ID loads a bubble.
- idex_flush, output, 1: ID/EX loads a bubble.
- exmem_en, output, 1: EX/MEM and MEM/WB load enable.
- state, output, 2: FSM state (RUN=0, MEM_WAIT=1, REDIRECT=2).
- stall_count, output, CNT_W: cycles with pc_en=0.
- flush_count, output, CNT_W: accepted redirects.

Behaviour:
- Reset (rst=0, async):
  - state=RUN, penalty counter=0, stall_count=0, flush_count=0.
  - Outputs forced while rst=0: pc_en=0, ifid_en=0, exmem_en=0, ifid_flush=1, idex_flush=1.
- State is registered. Outputs are combinational from state plus current inputs.
- Definition: lu = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Unless stated otherwise, an output not listed in a case below is 0 for that case.
- RUN, priority high to low:
  1. dmem_busy:
     - Freeze: pc_en=0, ifid_en=0, exmem_en=0, no flushes.
     - Next state MEM_WAIT.
  2. redirect:
     - pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, exmem_en=1.
     - flush_count+1.
     - Next state REDIRECT with counter=BR_PENALTY if BR_PENALTY>0; otherwise stay in RUN.
     - redirect overrides lu and !imem_ready.
  3. lu:
     - pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1.
     - Stay in RUN; the hazard clears after one cycle.
  4. !imem_ready:
     - pc_en=0, ifid_en=1, ifid_flush=1, exmem_en=1.
  5. Otherwise: pc_en=1, ifid_en=1, exmem_en=1, no flushes.
- MEM_WAIT:
  - Freeze exactly as in RUN case 1 while dmem_busy=1.
  - When dmem_busy=0: next state RUN. Outputs this cycle are evaluated with the RUN rules 2–5.
  - A redirect held during the freeze is therefore taken on the release cycle and is counted once.
- REDIRECT:
  - dmem_busy=1: freeze; counter holds; state holds.
  - Otherwise:
    - ifid_flush=1, ifid_en=1, exmem_en=1, pc_en=imem_ready.
    - Counter decrements only when imem_ready=1.
    - Go to RUN when the counter reaches 0 after the decrement.
  - redirect=1 in REDIRECT: handled as in RUN case 2, and the counter reloads to BR_PENALTY.
- Counters:
  - stall_count increments every non-reset cycle with pc_en=0.
  - Both counters saturate at all-ones and do not wrap.
  - clr_counters=1 zeroes both and has priority over increment in the same cycle.
- Illegal state 3: behaves as RUN and returns to RUN on the next clock.

Test Plan:
1. Release reset with imem_ready=1 and no hazards:
   - state=0, pc_en=1, ifid_en=1, exmem_en=1, no flushes.
   - Both counters stay 0 over 10 cycles.
2. Load-use on rs1: ex_mem_read=1, ex_rd=5, id_rs1=5 for one cycle:
   - pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_count=1.
   - Repeat with ex_rd=0: no stall.
   - Repeat with a match on rs2 and id_uses_rs2=0: no stall.
3. redirect pulse, BR_PENALTY=1:
   - Cycle 0: ifid_flush=1, idex_flush=1, pc_en=1, state→2.
   - Cycle 1: ifid_flush=1, then state→0.
   - flush_count=1.
   - With BR_PENALTY=0: state stays 0.
4. dmem_busy=1 for 3 cycles with redirect=1 held:
   - pc_en=0, ifid_en=0, exmem_en=0 for 3 cycles; state=1; stall_count=3.
   - On release: redirect outputs fire once; flush_count=1.
5. Simultaneous redirect and lu with imem_ready=0:
   - Redirect wins: pc_en=1, ifid_flush=1, idex_flush=1.
   - In REDIRECT with imem_ready=0 for 2 cycles: counter holds, state stays 2.
6. Counters and reset:
   - Force stall_count to all-ones with CNT_W=4: it holds at 15.
   - clr_counters together with a stall cycle: count becomes 0.
   - Assert rst mid-REDIRECT: immediately state=0, pc_en=0, flushes=1, counters=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. Load-use hazards,
// instruction-fetch wait, data-memory busy and EX-stage redirects (taken
// branch or jump) are merged into per-stage enable and flush strobes. Two
// saturating performance counters track stalled cycles and accepted redirects.
//
// Parameters
//   REG_W       register-index width
//   CNT_W       performance-counter width
//   BR_PENALTY  extra IF/ID bubble cycles after a redirect (0..7)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   id_rs1        rs1 of the instruction in ID
//   id_rs2        rs2 of the instruction in ID
//   id_uses_rs2   ID instruction reads rs2
//   ex_mem_read   EX instruction is a load
//   ex_rd         destination register of the EX instruction
//   redirect      taken branch or jump resolved in EX
//   imem_ready    instruction memory returns valid data this cycle
//   dmem_busy     data memory not done; the whole pipeline freezes
//   clr_counters  synchronous clear of both performance counters
//   pc_en         PC register load enable
//   ifid_en       IF/ID load enable
//   ifid_flush    IF/ID loads a bubble
//   idex_flush    ID/EX loads a bubble
//   exmem_en      EX/MEM and MEM/WB load enable
//   state         sequencer state (0 RUN, 1 MEM_WAIT, 2 REDIRECT)
//   stall_count   saturating count of cycles with pc_en=0
//   flush_count   saturating count of accepted redirects
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32,
  parameter int BR_PENALTY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             redirect,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  input  logic             clr_counters,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_REDIRECT = 2'd2,
    S_ILLEGAL  = 2'd3
  } state_e;

  // What the pipeline does this cycle. Every state funnels into one of these,
  // so the output and next-state logic share a single priority decision.
  typedef enum logic [2:0] {
    A_FREEZE   = 3'd0,
    A_REDIRECT = 3'd1,
    A_BUBBLE   = 3'd2,
    A_LOADUSE  = 3'd3,
    A_IFWAIT   = 3'd4,
    A_GO       = 3'd5
  } action_e;

  localparam logic [2:0]       PEN     = 3'(BR_PENALTY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [2:0]       pcnt_q, pcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  action_e          action;
  logic             lu;

  // Load-use: the load in EX writes a register the ID instruction reads.
  // x0 never carries a dependency.
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Priority decode. MEM_WAIT with dmem_busy low and the illegal encoding
  // both fall through to the RUN rules; only REDIRECT adds the bubble case,
  // and a fresh redirect still pre-empts it.
  always_comb begin
    action = A_GO;
    if (dmem_busy) begin
      action = A_FREEZE;
    end else if (redirect) begin
      action = A_REDIRECT;
    end else if (state_q == S_REDIRECT) begin
      action = A_BUBBLE;
    end else if (lu) begin
      action = A_LOADUSE;
    end else if (!imem_ready) begin
      action = A_IFWAIT;
    end else begin
      action = A_GO;
    end
  end

  // State register and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = S_RUN;
    pcnt_d  = pcnt_q;
    unique case (action)
      A_FREEZE: begin
        // A freeze inside the penalty window keeps the window intact;
        // anywhere else it parks in MEM_WAIT until memory releases.
        state_d = (state_q == S_REDIRECT) ? S_REDIRECT : S_MEM_WAIT;
      end
      A_REDIRECT: begin
        pcnt_d  = PEN;
        state_d = (PEN != 3'd0) ? S_REDIRECT : S_RUN;
      end
      A_BUBBLE: begin
        state_d = S_REDIRECT;
        if (imem_ready) begin
          // Only a fetched (and discarded) instruction consumes a bubble.
          if (pcnt_q <= 3'd1) begin
            pcnt_d  = '0;
            state_d = S_RUN;
          end else begin
            pcnt_d = pcnt_q - 3'd1;
          end
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    // Clear wins over increment; both counters stick at all-ones.
    if (clr_counters) begin
      stall_d = '0;
    end else if (!pc_en && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + 1'b1;
    end else begin
      stall_d = stall_q;
    end

    if (clr_counters) begin
      flush_d = '0;
    end else if ((action == A_REDIRECT) && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + 1'b1;
    end else begin
      flush_d = flush_q;
    end
  end

  // Output logic. While reset is held the pipeline is frozen with bubbles
  // injected so nothing stale escapes when reset releases.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    if (!rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      unique case (action)
        A_FREEZE: begin
        end
        A_REDIRECT: begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
        end
        A_BUBBLE: begin
          pc_en      = imem_ready;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          exmem_en   = 1'b1;
        end
        A_LOADUSE: begin
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
        end
        A_IFWAIT: begin
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          exmem_en   = 1'b1;
        end
        default: begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          exmem_en = 1'b1;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       uses2, mr, redir, imem, busy, clr;

  // Instance 0: penalty 1, 32-bit counters. Instance 1: penalty 3.
  // Instance 2: penalty 0 with 4-bit counters for saturation.
  logic [4:0]  pc_v, ife_v, iff_v, idf_v, ex_v;
  logic [1:0]  st0, st1, st2;
  logic [31:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32), .BR_PENALTY(1)) u_main (
    .clk(clk), .rst(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
    .ex_mem_read(mr), .ex_rd(rd), .redirect(redir), .imem_ready(imem),
    .dmem_busy(busy), .clr_counters(clr), .pc_en(pc_v[0]), .ifid_en(ife_v[0]),
    .ifid_flush(iff_v[0]), .idex_flush(idf_v[0]), .exmem_en(ex_v[0]),
    .state(st0), .stall_count(sc0), .flush_count(fc0));

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32), .BR_PENALTY(3)) u_p3 (
    .clk(clk), .rst(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
    .ex_mem_read(mr), .ex_rd(rd), .redirect(redir), .imem_ready(imem),
    .dmem_busy(busy), .clr_counters(clr), .pc_en(pc_v[1]), .ifid_en(ife_v[1]),
    .ifid_flush(iff_v[1]), .idex_flush(idf_v[1]), .exmem_en(ex_v[1]),
    .state(st1), .stall_count(sc1), .flush_count(fc1));

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4), .BR_PENALTY(0)) u_p0 (
    .clk(clk), .rst(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(uses2),
    .ex_mem_read(mr), .ex_rd(rd), .redirect(redir), .imem_ready(imem),
    .dmem_busy(busy), .clr_counters(clr), .pc_en(pc_v[2]), .ifid_en(ife_v[2]),
    .ifid_flush(iff_v[2]), .idex_flush(idf_v[2]), .exmem_en(ex_v[2]),
    .state(st2), .stall_count(sc2), .flush_count(fc2));

  int total = 0;
  int bad   = 0;

  // Output flag packing used everywhere: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en}
  localparam logic [4:0] F_GO  = 5'b11001;
  localparam logic [4:0] F_LU  = 5'b00011;
  localparam logic [4:0] F_IFW = 5'b01101;
  localparam logic [4:0] F_RD  = 5'b11111;
  localparam logic [4:0] F_BUB = 5'b11101;
  localparam logic [4:0] F_FRZ = 5'b00000;
  localparam logic [4:0] F_RST = 5'b00110;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       uses2, mr, redir, imem, busy, clr;
    logic [4:0] flags;
    int         st;
    longint     stall, flush;
  } row_t;

  row_t tbl[$];

  // Reference model: "parked in memory wait" flag plus number of bubble
  // cycles still owed after a redirect. The reported state follows from those.
  int     pen[3] = '{1, 3, 0};
  longint cap[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  bit     m_mw[3];
  int     m_bub[3];
  longint m_stall[3], m_flush[3];
  bit     n_mw[3];
  int     n_bub[3];
  longint n_stall[3], n_flush[3];
  logic [4:0] e_flags[3];
  int     e_st[3];

  task automatic chk(input string nm, input int k, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, k, got, want, $time);
    end
  endtask

  function automatic logic [4:0] dut_flags(input int k);
    return {pc_v[k], ife_v[k], iff_v[k], idf_v[k], ex_v[k]};
  endfunction

  function automatic int dut_st(input int k);
    return (k == 0) ? int'(st0) : (k == 1) ? int'(st1) : int'(st2);
  endfunction

  function automatic longint dut_stall(input int k);
    return (k == 0) ? longint'(sc0) : (k == 1) ? longint'(sc1) : longint'(sc2);
  endfunction

  function automatic longint dut_flush(input int k);
    return (k == 0) ? longint'(fc0) : (k == 1) ? longint'(fc1) : longint'(fc2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mw[k] = 0; m_bub[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  task automatic model_eval();
    bit hz;
    bit pc;
    hz = mr && (rd != 0) && ((rd == rs1) || (uses2 && (rd == rs2)));
    for (int k = 0; k < 3; k++) begin
      e_st[k]    = m_mw[k] ? 1 : (m_bub[k] > 0 ? 2 : 0);
      n_mw[k]    = 0;
      n_bub[k]   = m_bub[k];
      n_flush[k] = m_flush[k];
      if (busy) begin
        e_flags[k] = F_FRZ;
        n_mw[k]    = (m_bub[k] == 0);
      end else if (redir) begin
        e_flags[k] = F_RD;
        n_bub[k]   = pen[k];
        if (m_flush[k] < cap[k]) n_flush[k] = m_flush[k] + 1;
      end else if (m_bub[k] > 0) begin
        e_flags[k] = imem ? F_BUB : F_IFW;
        if (imem) n_bub[k] = m_bub[k] - 1;
      end else if (hz) begin
        e_flags[k] = F_LU;
      end else if (!imem) begin
        e_flags[k] = F_IFW;
      end else begin
        e_flags[k] = F_GO;
      end
      pc = e_flags[k][4];
      n_stall[k] = (!pc && m_stall[k] < cap[k]) ? m_stall[k] + 1 : m_stall[k];
      if (clr) begin
        n_stall[k] = 0;
        n_flush[k] = 0;
      end
    end
  endtask

  // Evaluate the model for the inputs already applied, then compare at negedge.
  task automatic cyc_begin();
    model_eval();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("outputs", k, longint'(dut_flags(k)), longint'(e_flags[k]));
      chk("state", k, longint'(dut_st(k)), longint'(e_st[k]));
      chk("stall_count", k, dut_stall(k), m_stall[k]);
      chk("flush_count", k, dut_flush(k), m_flush[k]);
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m_mw[k] = n_mw[k]; m_bub[k] = n_bub[k];
      m_stall[k] = n_stall[k]; m_flush[k] = n_flush[k];
    end
    #1;
  endtask

  task automatic cycle();
    cyc_begin();
    cyc_end();
  endtask

  task automatic set_idle();
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd0; uses2 = 0; mr = 0;
    redir = 0; imem = 1; busy = 0; clr = 0;
  endtask

  function automatic row_t mk(input logic [4:0] a1, a2, input logic u2, m, input logic [4:0] d,
                              input logic rdr, im, bz, cl, input logic [4:0] fl,
                              input int s, input longint sc, fc);
    row_t r;
    r.rs1 = a1; r.rs2 = a2; r.uses2 = u2; r.mr = m; r.rd = d;
    r.redir = rdr; r.imem = im; r.busy = bz; r.clr = cl;
    r.flags = fl; r.st = s; r.stall = sc; r.flush = fc;
    return r;
  endfunction

  function automatic row_t idle(input logic [4:0] fl, input int s, input longint sc, fc);
    return mk(5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 0, fl, s, sc, fc);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rst = 1'b0;
    model_reset();

    // Directed sequence for instance 0 (penalty 1), one row per cycle.
    for (int i = 0; i < 10; i++) tbl.push_back(idle(F_GO, 0, 0, 0));
    tbl.push_back(mk(5'd5, 5'd2, 0, 1, 5'd5, 0, 1, 0, 0, F_LU, 0, 0, 0));  // lu on rs1
    tbl.push_back(idle(F_GO, 0, 1, 0));
    tbl.push_back(mk(5'd0, 5'd2, 0, 1, 5'd0, 0, 1, 0, 0, F_GO, 0, 1, 0));  // rd = x0
    tbl.push_back(mk(5'd1, 5'd7, 0, 1, 5'd7, 0, 1, 0, 0, F_GO, 0, 1, 0));  // rs2 unused
    tbl.push_back(mk(5'd1, 5'd7, 1, 1, 5'd7, 0, 1, 0, 0, F_LU, 0, 1, 0));  // rs2 used
    tbl.push_back(idle(F_GO, 0, 2, 0));
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, 0, F_RD, 0, 2, 0));  // redirect
    tbl.push_back(idle(F_BUB, 2, 2, 1));
    tbl.push_back(idle(F_GO, 0, 2, 1));
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 1, 0, F_FRZ, 0, 2, 1)); // busy + redirect x3
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 1, 0, F_FRZ, 1, 3, 1));
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 1, 0, F_FRZ, 1, 4, 1));
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, 0, F_RD, 1, 5, 1));  // release
    tbl.push_back(idle(F_BUB, 2, 5, 2));
    tbl.push_back(idle(F_GO, 0, 5, 2));
    tbl.push_back(mk(5'd5, 5'd2, 0, 1, 5'd5, 1, 0, 0, 0, F_RD, 0, 5, 2));  // redirect beats lu
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, F_IFW, 2, 5, 3)); // bubble, no fetch
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, F_IFW, 2, 6, 3));
    tbl.push_back(idle(F_BUB, 2, 7, 3));
    tbl.push_back(idle(F_GO, 0, 7, 3));
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, F_IFW, 0, 7, 3)); // fetch wait
    tbl.push_back(mk(5'd5, 5'd2, 0, 1, 5'd5, 0, 1, 0, 1, F_LU, 0, 8, 3));  // clr + stall
    tbl.push_back(idle(F_GO, 0, 0, 0));
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, 0, F_RD, 0, 0, 0));
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, 0, F_RD, 2, 0, 1));  // redirect in REDIRECT
    tbl.push_back(idle(F_BUB, 2, 0, 2));
    tbl.push_back(idle(F_GO, 0, 0, 2));
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, 0, F_RD, 0, 0, 2));
    tbl.push_back(mk(5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 1, 0, F_FRZ, 2, 0, 3)); // busy in REDIRECT
    tbl.push_back(idle(F_BUB, 2, 1, 3));
    tbl.push_back(idle(F_GO, 0, 1, 3));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_outputs", k, longint'(dut_flags(k)), longint'(F_RST));
      chk("reset_state", k, longint'(dut_st(k)), 0);
      chk("reset_stall", k, dut_stall(k), 0);
      chk("reset_flush", k, dut_flush(k), 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;

    foreach (tbl[i]) begin
      rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; uses2 = tbl[i].uses2; mr = tbl[i].mr;
      rd = tbl[i].rd; redir = tbl[i].redir; imem = tbl[i].imem;
      busy = tbl[i].busy; clr = tbl[i].clr;
      cyc_begin();
      chk($sformatf("tbl%0d_outputs", i), 0, longint'(dut_flags(0)), longint'(tbl[i].flags));
      chk($sformatf("tbl%0d_state", i), 0, longint'(st0), longint'(tbl[i].st));
      chk($sformatf("tbl%0d_stall", i), 0, longint'(sc0), tbl[i].stall);
      chk($sformatf("tbl%0d_flush", i), 0, longint'(fc0), tbl[i].flush);
      cyc_end();
    end

    // 4-bit stall counter saturates at 15 over a long fetch wait.
    set_idle();
    imem = 0;
    repeat (20) cycle();
    chk("sat_stall_4bit", 2, longint'(sc2), 15);
    imem = 1;
    cycle();
    chk("sat_hold_4bit", 2, longint'(sc2), 15);

    // Redirect: penalty 0 stays in RUN, penalty 1 and 3 enter REDIRECT.
    redir = 1;
    cycle();
    redir = 0;
    chk("pen0_state", 2, longint'(st2), 0);
    chk("pen1_state", 0, longint'(st0), 2);
    chk("pen3_state", 1, longint'(st1), 2);
    repeat (4) cycle();
    chk("pen3_back_to_run", 1, longint'(st1), 0);

    // Asynchronous reset in the middle of a penalty window.
    redir = 1;
    cycle();
    redir = 0;
    chk("pre_reset_state", 0, longint'(st0), 2);
    rst = 1'b0;
    #1;
    chk("async_rst_state", 0, longint'(st0), 0);
    chk("async_rst_outputs", 0, longint'(dut_flags(0)), longint'(F_RST));
    chk("async_rst_stall", 0, longint'(sc0), 0);
    chk("async_rst_flush", 0, longint'(fc0), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 3));
      uses2 = 1'($urandom_range(0, 1));
      mr    = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 5) == 0);
      imem  = ($urandom_range(0, 3) != 0);
      busy  = ($urandom_range(0, 5) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
